mult_div_unit: RTL

- EX-stage iterative multiply/divide unit for the pipelined MIPS core.
- Consumes the two register-file read operands (rs, rt) and produces the architectural HI/LO registers for MULT/MULTU/DIV/DIVU, MFHI/MFLO, MTHI and MTLO.
- Uses a 32-iteration shift-add/restoring datapath with a start/busy/done handshake. The hazard unit stalls on busy.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sign_fix.sv | 46 ++++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
// The signed MULT/DIV datapath is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Signed so that a size cast replicates the ones for any WIDTH.
    localparam logic signed [WIDTH_DEF-1:0] QUOT_DIV0 = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement magnitude conversion on operand entry and conditional
// negation of the raw HI/LO result on exit (signed MULT/DIV only).
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    output logic [WIDTH-1:0]   rs_mag,
    output logic [WIDTH-1:0]   rt_mag,
    output logic               prod_neg,
    output logic               rem_neg,
    input  logic               is_div,
    input  logic               prod_neg_q,
    input  logic               rem_neg_q,
    input  logic [2*WIDTH-1:0] raw,
    output logic [2*WIDTH-1:0] fixed
);

    logic rs_neg;
    logic rt_neg;

    assign rs_neg = is_signed & rs_data[WIDTH-1];
    assign rt_neg = is_signed & rt_data[WIDTH-1];

    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // Product and quotient are negative on a sign mismatch; the remainder
    // follows the dividend.
    assign prod_neg = rs_neg ^ rt_neg;
    assign rem_neg  = rs_neg;

    always_comb begin
        fixed = raw;
        if (!is_div) begin
            if (prod_neg_q) fixed = -raw;
        end else begin
            if (rem_neg_q)  fixed[2*WIDTH-1:WIDTH] = -raw[2*WIDTH-1:WIDTH];
            if (prod_neg_q) fixed[WIDTH-1:0]       = -raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the MIPS HI/LO
// registers. Signed MULT/DIV is built only when MULDIV_SIGNED_EN is defined.
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_wr,
    input  logic             lo_wr,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e               state;
    state_e               state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   result_fix;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [CNT_W-1:0]     cnt;
    logic                 div_q;
    logic                 div0_q;
    logic                 is_div;
    logic                 last_iter;
    logic                 accept;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic                 unused_div_msb;

    assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: multiply adds into the upper half then shifts right;
    // divide shifts the remainder left and keeps the trial difference if it
    // did not borrow, shifting the quotient bit into the lower half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        acc_step  = acc;
        if (div_q) begin
            if (!div_diff[WIDTH+1])
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // A non-borrowing difference is always below the divisor, so its top
    // magnitude bit is never needed.
    assign unused_div_msb = div_diff[WIDTH];

    // NOTE: the working datapath has no reset; it is always loaded on start
    // before use, and reset returns the FSM to IDLE so stale contents are
    // never written to HI/LO.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            b_q    <= b_mag;
            cnt    <= '0;
            div_q  <= is_div;
            div0_q <= is_div && (rt_data == '0);
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef MULDIV_SIGNED_EN
    logic is_signed;
    logic prod_neg;
    logic rem_neg;
    logic prod_neg_q;
    logic rem_neg_q;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    always_ff @(posedge clk) begin
        if (accept) begin
            prod_neg_q <= prod_neg;
            rem_neg_q  <= rem_neg;
        end
    end

    muldiv_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .is_signed  (is_signed),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .rs_mag     (a_mag),
        .rt_mag     (b_mag),
        .prod_neg   (prod_neg),
        .rem_neg    (rem_neg),
        .is_div     (div_q),
        .prod_neg_q (prod_neg_q),
        .rem_neg_q  (rem_neg_q),
        .raw        (acc),
        .fixed      (result_fix)
    );
`else
    assign a_mag      = rs_data;
    assign b_mag      = rt_data;
    assign result_fix = acc;
`endif

    // Architectural HI/LO: written only by FIX or an idle MTHI/MTLO that is
    // not overridden by a simultaneous start. Divide by zero keeps the
    // naturally produced remainder (the dividend) and forces an all-ones
    // quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                hi <= result_fix[2*WIDTH-1:WIDTH];
                lo <= div0_q ? WIDTH'(QUOT_DIV0) : result_fix[WIDTH-1:0];
            end else if ((state == IDLE) && !start) begin
                if (hi_wr) hi <= rs_data;
                if (lo_wr) lo <= rs_data;
            end
        end
    end

endmodule
